// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular-buffer FIFO. LSB-first frames: one start bit,
// DATA_BITS data bits, STOP_BITS stop bits, no parity; the FSM advances only on Tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 WrEn,
  output logic                 Full,
  output logic                 Empty,
  output logic [CNT_W-1:0]     Count,
  output logic                 Busy,
  output logic                 Tx
);

  localparam int unsigned PtrW = (CNT_W > 1) ? CNT_W - 1 : 1;
  localparam int unsigned BitW = 3;
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);
  localparam logic             LastStop = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;

  logic push;
  logic pop;

  // Full is the registered flag, so a write on a pop edge while full is still dropped.
  assign push = WrEn && !full_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    if (Tick) begin
      case (state_q)
        StIdle: begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d = 1'b1;
          end
        end
        StStart: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = StData;
        end
        StData: begin
          if (bit_cnt_q != LastBit) begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end
        end
        StStop: begin
          if (stop_cnt_q != LastStop) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (!empty_q) begin
            // Back-to-back frame: start bit follows the last stop bit directly.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = DataIn;
    end
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign Tx    = tx_q;
  assign Busy  = (state_q != StIdle);
  assign Full  = full_q;
  assign Empty = empty_q;
  assign Count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed frame sequences and random traffic checked
// against a queue-based frame model; a second instance covers 7 data bits / 2 stop bits.
module tb_uart_tx_fifo;

  localparam int D1    = 8;
  localparam int S1    = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, tick = 1'b0, wr = 1'b0;
  logic [7:0] din = '0;
  logic       full, empty, busy, tx;
  logic [2:0] count;

  logic       rst2 = 1'b0, tick2 = 1'b0, wr2 = 1'b0;
  logic [6:0] din2 = '0;
  logic       full2, empty2, busy2, tx2;
  logic [2:0] count2;

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) u_dut (
    .Clk(clk), .Reset(rst), .Tick(tick), .DataIn(din), .WrEn(wr),
    .Full(full), .Empty(empty), .Count(count), .Busy(busy), .Tx(tx)
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) u_dut2 (
    .Clk(clk), .Reset(rst2), .Tick(tick2), .DataIn(din2), .WrEn(wr2),
    .Full(full2), .Empty(empty2), .Count(count2), .Busy(busy2), .Tx(tx2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the FIFO is a queue; a running frame is a list of line levels still
  // to be shown, one per Tick.
  logic [7:0] q_m[$];
  bit         pend_m[$];
  bit         tx_m   = 1'b1;
  bit         busy_m = 1'b0;

  task automatic model_edge(input logic r, input logic t, input logic w, input logic [7:0] d);
    logic [7:0] b;
    bit         full_pre;
    if (r) begin
      q_m.delete();
      pend_m.delete();
      tx_m   = 1'b1;
      busy_m = 1'b0;
    end else begin
      full_pre = (q_m.size() == DEPTH);
      if (t) begin
        if (busy_m && pend_m.size() != 0) begin
          tx_m = pend_m.pop_front();
        end else if (q_m.size() != 0) begin
          b      = q_m.pop_front();
          tx_m   = 1'b0;
          busy_m = 1'b1;
          for (int i = 0; i < D1; i++) pend_m.push_back(b[i]);
          for (int i = 0; i < S1; i++) pend_m.push_back(1'b1);
        end else begin
          tx_m   = 1'b1;
          busy_m = 1'b0;
        end
      end
      if (w && !full_pre) q_m.push_back(d);
    end
  endtask

  bit         got_lv[$];
  bit         exp_lv[$];
  logic [7:0] dec_q[$];
  int         busy_tk;

  task automatic step(input logic r, input logic t, input logic w, input logic [7:0] d);
    rst = r; tick = t; wr = w; din = d;
    @(posedge clk);
    model_edge(r, t, w, d);
    #1;
    check("tx", int'(tx), int'(tx_m));
    check("busy", int'(busy), int'(busy_m));
    check("count", int'(count), q_m.size());
    check("full", int'(full), int'(q_m.size() == DEPTH));
    check("empty", int'(empty), int'(q_m.size() == 0));
    if (t) begin
      got_lv.push_back(tx);
      if (busy) busy_tk++;
    end
    rst = 1'b0; tick = 1'b0; wr = 1'b0;
  endtask

  task automatic step2(input logic r, input logic t, input logic w, input logic [6:0] d);
    rst2 = r; tick2 = t; wr2 = w; din2 = d;
    @(posedge clk);
    #1;
    if (t) begin
      got_lv.push_back(tx2);
      if (busy2) busy_tk++;
    end
    rst2 = 1'b0; tick2 = 1'b0; wr2 = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b, input int d, input int s);
    exp_lv.push_back(1'b0);
    for (int i = 0; i < d; i++) exp_lv.push_back(b[i]);
    for (int i = 0; i < s; i++) exp_lv.push_back(1'b1);
  endtask

  task automatic cmp_levels(input string name, input int n);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got_lv.size() || i >= exp_lv.size()) mism++;
      else if (got_lv[i] != exp_lv[i]) mism++;
    end
    check(name, mism, 0);
  endtask

  // Recover 8-bit frames from the per-Tick line levels of the default instance.
  task automatic decode();
    int         i;
    logic [7:0] b;
    dec_q.delete();
    i = 0;
    while (i < got_lv.size()) begin
      if (got_lv[i] == 1'b0 && i + 9 < got_lv.size()) begin
        for (int j = 0; j < 8; j++) b[j] = got_lv[i + 1 + j];
        dec_q.push_back(b);
        i += 10;
      end else begin
        i++;
      end
    end
  endtask

  typedef struct {
    logic       rst, tick, wr;
    logic [7:0] din;
    logic       tx, busy;
    int         cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [9:0] a5e;
    logic [9:0] s2e;
    bit         samp[48];
    int         bz;
    int         mism;
    logic       r, t, w;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 4};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 4};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].wr, vecs[i].din);
      check($sformatf("vec%0d_tx", i), int'(tx), int'(vecs[i].tx));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      check($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].cnt == 4));
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].cnt == 0));
    end

    // 0xA5 with a Tick every 4 clocks.
    a5e = 10'b1101001010;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    bz = 0;
    for (int c = 0; c < 48; c++) begin
      step(1'b0, (c % 4) == 0, 1'b0, 8'h00);
      samp[c] = tx;
      if (busy) bz++;
      if (c == 0) check("a5_empty_on_pop", int'(empty), 1);
    end
    for (int i = 0; i < 10; i++) begin
      mism = 0;
      for (int k = 0; k < 4; k++) if (samp[4 * i + k] != a5e[i]) mism++;
      check($sformatf("a5_bit%0d", i), mism, 0);
    end
    check("a5_busy_cycles", bz, 40);

    // 0x00 then 0xFF back to back.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    got_lv.delete(); exp_lv.delete(); busy_tk = 0;
    for (int c = 0; c < 24; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
    push_frame(8'h00, 8, 1);
    push_frame(8'hFF, 8, 1);
    cmp_levels("b2b_levels", 20);
    check("b2b_busy_ticks", busy_tk, 20);

    // Five writes with Tick low: the fifth is dropped.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 8'((k + 1) * 17));
    check("fill_count", int'(count), 4);
    check("fill_full", int'(full), 1);
    got_lv.delete();
    for (int c = 0; c < 100; c++) step(1'b0, (c % 2) == 0, 1'b0, 8'h00);
    decode();
    check("fill_nbytes", dec_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("fill_byte", (i < dec_q.size()) ? int'(dec_q[i]) : -1, (i + 1) * 17);

    // Writes landing on pop edges, first with the FIFO full, then with Count=3.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hA1);
    step(1'b0, 1'b0, 1'b1, 8'hB2);
    step(1'b0, 1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 1'b1, 8'hD4);
    got_lv.delete();
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check("full_pop_drop", int'(count), 3);
    for (int c = 0; c < 9; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h99);
    check("pop_write_keep", int'(count), 3);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
    decode();
    check("popw_nbytes", dec_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      int e;
      case (i)
        0: e = 'hA1;
        1: e = 'hB2;
        2: e = 'hC3;
        3: e = 'hD4;
        default: e = 'h99;
      endcase
      check("popw_byte", (i < dec_q.size()) ? int'(dec_q[i]) : -1, e);
    end

    // Reset during data bit 3 of 0xC3 with another byte queued.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hC3);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b1, 1'b1, 8'h12);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    step(1'b0, 1'b0, 1'b1, 8'h5A);
    got_lv.delete();
    for (int c = 0; c < 14; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
    decode();
    check("rst_nbytes", dec_q.size(), 1);
    check("rst_byte", (dec_q.size() > 0) ? int'(dec_q[0]) : -1, 'h5A);

    // Random traffic against the model.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      t = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      w = ($urandom_range(0, 2) == 0);
      step(r, t, w, 8'($urandom));
    end

    // 7 data bits, 2 stop bits.
    s2e = 10'b1110000010;
    step2(1'b1, 1'b0, 1'b0, 7'h00);
    step2(1'b0, 1'b0, 1'b1, 7'h41);
    got_lv.delete(); busy_tk = 0;
    for (int c = 0; c < 12; c++) step2(1'b0, 1'b1, 1'b0, 7'h00);
    mism = 0;
    for (int i = 0; i < 10; i++) if (got_lv[i] != s2e[i]) mism++;
    check("s2_levels", mism, 0);
    check("s2_busy_ticks", busy_tk, 10);
    check("s2_idle_line", int'(got_lv[10]), 1);
    check("s2_idle_busy", int'(busy2), 0);

    step2(1'b0, 1'b0, 1'b1, 7'h41);
    step2(1'b0, 1'b0, 1'b1, 7'h2A);
    check("s2_count", int'(count2), 2);
    check("s2_notfull", int'(full2), 0);
    got_lv.delete(); exp_lv.delete(); busy_tk = 0;
    for (int c = 0; c < 22; c++) step2(1'b0, 1'b1, 1'b0, 7'h00);
    push_frame(8'h41, 7, 2);
    push_frame(8'h2A, 7, 2);
    cmp_levels("s2_b2b_levels", 20);
    check("s2_b2b_busy_ticks", busy_tk, 20);
    check("s2_b2b_empty", int'(empty2), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
